// File: rtl/voice_mixer.sv
// voice_mixer: masks, sums, attenuates and saturates three voice samples into one codec sample.
//   Ports: clk, reset (sync, active-high), new_sample_in strobe with wave1..wave3,
//   toggle_pulse/mute_all edit the voice enable mask, clip_clear zeroes clip_count;
//   outputs sample_out/sample_valid (3-cycle latency), voice_en, clip_count, peak_level.
//   Optional peak meter enabled by defining VOICE_MIX_PEAK_EN (else peak_level = 0).
module voice_mixer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN_SHIFT   = 2,
  parameter int PEAK_DECAY   = 4800
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_in,
  input  logic [SAMPLE_WIDTH-1:0] wave1,
  input  logic [SAMPLE_WIDTH-1:0] wave2,
  input  logic [SAMPLE_WIDTH-1:0] wave3,
  input  logic [2:0]              toggle_pulse,
  input  logic                    mute_all,
  input  logic                    clip_clear,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_valid,
  output logic [2:0]              voice_en,
  output logic [7:0]              clip_count,
  output logic [3:0]              peak_level
);
  localparam int SW = SAMPLE_WIDTH;
  localparam int AW = SW + 2;
  localparam logic signed [AW-1:0] MAXV = {3'b000, {(SW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {3'b111, {(SW-1){1'b0}}};
  logic [2:0]           voice_en_q, voice_en_d;
  logic [SW-1:0]        w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic signed [AW-1:0] sum_q, sum_d, shifted, sat;
  logic [SW-1:0]        sample_out_q, sample_out_d;
  logic                 sample_valid_q, sample_valid_d;
  logic [7:0]           clip_count_q, clip_count_d;
  logic                 clip;
  always_comb begin
    voice_en_d     = mute_all ? 3'b000 : voice_en_q ^ toggle_pulse;
    v1_d           = new_sample_in;
    w1_d           = new_sample_in ? (voice_en_q[0] ? wave1 : '0) : w1_q;
    w2_d           = new_sample_in ? (voice_en_q[1] ? wave2 : '0) : w2_q;
    w3_d           = new_sample_in ? (voice_en_q[2] ? wave3 : '0) : w3_q;
    v2_d           = v1_q;
    sum_d          = {{2{w1_q[SW-1]}}, w1_q} + {{2{w2_q[SW-1]}}, w2_q} + {{2{w3_q[SW-1]}}, w3_q};
    shifted        = sum_q >>> GAIN_SHIFT;
    sat            = shifted > MAXV ? MAXV : shifted < MINV ? MINV : shifted;
    clip           = v2_q && (sat != shifted);
    sample_valid_d = v2_q;
    sample_out_d   = v2_q ? sat[SW-1:0] : sample_out_q;
    clip_count_d   = clip_clear ? 8'd0 : (clip && clip_count_q != 8'hFF) ? clip_count_q + 8'd1 : clip_count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      voice_en_q     <= 3'b111;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      clip_count_q   <= '0;
    end else begin
      voice_en_q     <= voice_en_d;
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      clip_count_q   <= clip_count_d;
    end
    w1_q  <= w1_d;
    w2_q  <= w2_d;
    w3_q  <= w3_d;
    sum_q <= sum_d;
  end
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign voice_en     = voice_en_q;
  assign clip_count   = clip_count_q;
`ifdef VOICE_MIX_PEAK_EN
  localparam int CW = $clog2(PEAK_DECAY + 1);
  logic [3:0]    peak_q, peak_d, lvl;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] mag;
  logic          hit, dec;
  always_comb begin
    // -full_scale has no positive twin, so clamp it to +full_scale
    mag    = !sample_out_q[SW-1] ? sample_out_q :
             sample_out_q == {1'b1, {(SW-1){1'b0}}} ? {1'b0, {(SW-1){1'b1}}} : -sample_out_q;
    lvl    = mag[SW-2:SW-5];
    hit    = lvl >= peak_q;
    dec    = cnt_q == CW'(PEAK_DECAY - 1);
    peak_d = !sample_valid_q ? peak_q : hit ? lvl : dec ? peak_q - 4'd1 : peak_q;
    cnt_d  = !sample_valid_q ? cnt_q : (hit || dec) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q <= '0;
      cnt_q  <= '0;
    end else begin
      peak_q <= peak_d;
      cnt_q  <= cnt_d;
    end
  end
  assign peak_level = peak_q;
`else
  assign peak_level = 4'd0;
`endif
endmodule
